// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the write-back stage and register file.
package wb_regfile_pkg;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  typedef logic [31:0]           reg_bus_t;
  typedef logic [RegNumLog2-1:0] reg_addr_t;

  localparam reg_bus_t  ZeroWord   = 32'h0;
  localparam reg_addr_t NOPRegAddr = 5'b0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic RstEnable    = 1'b0;

  typedef struct packed {
    reg_addr_t wd;
    logic      wreg;
    reg_bus_t  wdata;
  } wb_entry_t;

  localparam wb_entry_t WbBubble = '{wd: NOPRegAddr, wreg: WriteDisable, wdata: ZeroWord};

endpackage

// File: rtl/wb_regfile_regfile.sv
// Architectural register array: commit port plus raw (unbypassed) read ports.
module regfile
  import wb_regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int NUM_RD  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [RegNumLog2-1:0]              waddr,
  input  logic [31:0]                        wdata,
  input  logic [NUM_RD-1:0][RegNumLog2-1:0]  raddr,
  output logic [NUM_RD-1:0][31:0]            rdata
);

  reg_bus_t regs [REG_NUM];

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZeroWord;
    end else if (we == WriteEnable && waddr != NOPRegAddr) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign rdata[gi] = regs[raddr[gi]];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back latch, commit into the register file, and bypassed decode read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        re1_i,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic        re2_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o
);

  localparam int NUM_RD = 2;

  wb_entry_t wb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable)  wb_q <= WbBubble;
    else if (flush_i)      wb_q <= WbBubble;
    else if (stall_i == NoStop)
      wb_q <= '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};
  end

  assign wb_wd_o    = wb_q.wd;
  assign wb_wreg_o  = wb_q.wreg;
  assign wb_wdata_o = wb_q.wdata;

  logic [NUM_RD-1:0]                 re;
  logic [NUM_RD-1:0][RegNumLog2-1:0] raddr;
  logic [NUM_RD-1:0][31:0]           raw;
  logic [NUM_RD-1:0][31:0]           rdata;

  assign re    = {re2_i, re1_i};
  assign raddr = {raddr2_i, raddr1_i};

  // Commit runs every edge regardless of stall; re-writing a held entry is harmless.
  regfile #(.REG_NUM(REG_NUM), .NUM_RD(NUM_RD)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_q.wreg),
    .waddr (wb_q.wd),
    .wdata (wb_q.wdata),
    .raddr (raddr),
    .rdata (raw)
  );

  // Bypass only from the latched entry; execute-stage forwarding lives in decode.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rp
    assign rdata[gi] = (rst == RstEnable || re[gi] == ReadDisable || raddr[gi] == NOPRegAddr)
                       ? ZeroWord
                       : (wb_q.wreg == WriteEnable && raddr[gi] == wb_q.wd) ? wb_q.wdata
                       : raw[gi];
  end

  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

endmodule
